snake_cmd_decoder: RTL
======================

Name: snake_cmd_decoder

Overview:
- FPGA-side consumer of the 7-bit command word that the HPS writes to the snake command conduit.
- Synchronises the command word and detects new commands by a toggle bit.
- Decodes and validates each command, then runs the game-control FSM (idle/run/pause/over).
- Generates the game-step tick from the selected speed and returns a 7-bit status word for the state-export readback.

Parameters:
- TICK_BASE, 500000: clock cycles per speed unit of the step period.
- SYNC_STAGES, 2: synchroniser flops on cmd_in, minimum 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_in  in  7  command word from HPS. [6]=seq toggle, [5:3]=opcode, [2:0]=arg.
- game_over  in  1  level from game logic, sampled in RUN only.
- step_tick  out  1  one-cycle pulse per game step, only in RUN.
- dir  out  2  applied heading. 0=UP, 1=RIGHT, 2=DOWN, 3=LEFT.
- game_rst  out  1  one-cycle pulse that clears the board.
- status_out  out  7  [6]=ack seq, [5:4]=state, [3:2]=dir, [1]=err sticky, [0]=busy.

Behaviour:
- Reset values (async on reset_n low): state=IDLE(0), dir=RIGHT, speed=4, ack seq=0, err=0, step_tick=0, game_rst=0, synchroniser=0, tick counter=0. Hence status_out=7'b0000100.
- Synchronisation: cmd_in passes through SYNC_STAGES flops. A command is "new" when synced[6] != ack seq.
- Acceptance: each new command is decoded exactly once.
  - ack seq <= synced[6] on the decode cycle.
  - status_out reflects the result 1 cycle after decode.
  - Total cmd_in to ack latency is SYNC_STAGES+2 cycles.
- busy is high from new-command detect until ack updates.
- Opcodes:
  - 0 NOP: acked, no effect.
  - 1 START: IDLE or OVER -> RUN. Pulses game_rst; dir set to RIGHT; tick counter cleared.
  - 2 PAUSE: RUN -> PAUSE.
  - 3 RESUME: PAUSE -> RUN. Tick counter continues from its held value.
  - 4 DIR: arg[1:0] becomes the pending heading.
  - 5 SPEED: speed <= arg (0..7). Takes effect at the next period reload.
  - 6 RESET_GAME: any state -> IDLE. Pulses game_rst; clears err.
  - 7: illegal. Sets err, no state change.
- Any opcode not legal in the current state (e.g. PAUSE in IDLE) sets err and is still acked.
- FSM states: IDLE=0, RUN=1, PAUSE=2, OVER=3.
  - RUN with game_over=1 -> OVER on the next clk; no further step_tick.
- Tick generation:
  - Counter runs only in RUN.
  - Period = TICK_BASE*(8-speed) cycles; speed 7 gives TICK_BASE, speed 0 gives 8*TICK_BASE.
  - On terminal count: step_tick=1 for one cycle and the counter reloads using the current speed.
  - Counter is 25-bit minimum, sized from TICK_BASE*8 via $clog2.
- Direction:
  - A pending heading is applied to dir on the step_tick cycle.
  - A pending heading that is the 180° reverse of the current dir, i.e. (pending^dir)==2, is dropped and sets err.
  - Without the optional feature, a later DIR command overwrites the pending heading.
- Simultaneous events:
  - game_over and a new command in the same cycle: game_over wins the transition; the command is still acked and evaluated against OVER.
  - step_tick on the same cycle as PAUSE decode: the tick fires, then the FSM goes to PAUSE.
- Reset mid-operation returns all outputs to reset values asynchronously. The first command after reset is accepted only if its seq bit is 1.

Optional Feature:
- Macro SNAKE_CMD_DIR_QUEUE_EN.
- Defined: 2-entry direction FIFO replaces the single pending register.
  - One entry is popped per step_tick.
  - Reversal is checked against the last queued heading, or against dir if the FIFO is empty.
  - A push when full is dropped and sets err.
  - The FIFO is flushed on START, RESET_GAME and OVER entry.
- Undefined: single overwrite pending register as described in Behaviour.

Decomposition:
- Package snake_pkg holds:
  - opcode localparams OP_NOP..OP_RSVD;
  - state enum IDLE/RUN/PAUSE/OVER (2-bit);
  - dir encodings;
  - status bit-position constants;
  - STATUS_RESET constant.
- Sub-module snake_step_timer: counter, reload from speed, enable and clear inputs, step_tick output.

Test Plan:
- Reset then idle: after reset_n deassert, status_out=7'h04, step_tick never pulses for 10*TICK_BASE cycles.
- Start command (TICK_BASE=10 in sim): cmd_in=7'b1_001_000 -> ack[6]=1 and state=RUN within SYNC_STAGES+2 cycles, one game_rst pulse, first step_tick 40 cycles later (speed 4).
- Direction and reversal: in RUN with dir=RIGHT, DIR UP (7'b0_100_000) -> dir=0 at the next step_tick. Then DIR DOWN (seq 1) -> dropped, err=1, dir stays 0.
- Speed, pause and resume: SPEED 7 -> period 10 after the next reload. PAUSE holds step_tick low for 100 cycles. RESUME -> tick resumes with the remaining count, no extra pulse.
- Game over race: game_over=1 on the same cycle a PAUSE is decoded -> state=OVER, err=1, ack toggles. START then returns to RUN with dir=RIGHT.
- Illegal command and reset mid-run: opcode 7 -> err=1, state unchanged. reset_n pulsed low mid-period -> status_out=7'h04 immediately, asynchronously.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared opcodes, FSM state encoding, headings and status-word layout for the
// snake command decoder.
package snake_pkg;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_START      = 3'd1;
  localparam logic [2:0] OP_PAUSE      = 3'd2;
  localparam logic [2:0] OP_RESUME     = 3'd3;
  localparam logic [2:0] OP_DIR        = 3'd4;
  localparam logic [2:0] OP_SPEED      = 3'd5;
  localparam logic [2:0] OP_RESET_GAME = 3'd6;
  localparam logic [2:0] OP_RSVD       = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int STB_BUSY  = 0;
  localparam int STB_ERR   = 1;
  localparam int STB_DIR   = 2;
  localparam int STB_STATE = 4;
  localparam int STB_ACK   = 6;

  localparam logic [2:0] SPEED_RESET  = 3'd4;
  localparam logic [6:0] STATUS_RESET = 7'b000_0100;

  // Headings differ by 2 exactly when they point in opposite directions.
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == DIR_DOWN;
  endfunction

endpackage

// File: rtl/snake_cmd_decoder_if.sv
// Command/status conduit between the HPS-side command word and the game logic.
interface snake_cmd_decoder_if;
  logic [6:0] cmd_in;
  logic       game_over;
  logic       step_tick;
  logic [1:0] dir;
  logic       game_rst;
  logic [6:0] status_out;

  modport master (
    output cmd_in, game_over,
    input  step_tick, dir, game_rst, status_out
  );

  modport slave (
    input  cmd_in, game_over,
    output step_tick, dir, game_rst, status_out
  );
endinterface

// File: rtl/snake_step_timer.sv
// Game-step period counter: counts while enabled, pulses step_tick on terminal
// count and reloads the period from the speed presented at that moment.
module snake_step_timer #(
  parameter int TICK_BASE = 500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] speed,
  output logic       step_tick
);

  localparam int CW = ($clog2(TICK_BASE * 8) > 25) ? $clog2(TICK_BASE * 8) : 25;

  function automatic logic [CW-1:0] term_of(input logic [2:0] spd);
    return CW'(TICK_BASE * (8 - int'(spd)) - 1);
  endfunction

  logic [CW-1:0] cnt_q, term_q;

  // term_q latches the period so a speed change only lands on the next reload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      term_q    <= term_of(3'd4);
      step_tick <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      if (clr) begin
        cnt_q  <= '0;
        term_q <= term_of(speed);
      end else if (en) begin
        if (cnt_q == term_q) begin
          cnt_q     <= '0;
          term_q    <= term_of(speed);
          step_tick <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/snake_cmd_decoder.sv
// Snake command decoder: synchronises the HPS command word, decodes toggled
// commands, runs the game FSM and step timer. SNAKE_CMD_DIR_QUEUE_EN selects a
// 2-entry heading FIFO instead of the single overwrite pending register.
module snake_cmd_decoder
  import snake_pkg::*;
#(
  parameter int TICK_BASE   = 500000,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               reset_n,
  snake_cmd_decoder_if.slave bus
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NS-1:0][6:0] sync_q;
  logic [6:0] synced;
  logic [2:0] op, arg;
  logic       new_cmd;

  state_e     state_q, eff_state, nxt_state;
  logic [1:0] dir_q;
  logic [2:0] speed_q;
  logic       ack_q, err_q, game_rst_q;
  logic [6:0] status_q, status_d;

  logic over_now, set_err, clr_err, rst_pulse, tmr_clr, speed_we;
  logic dir_push, force_right, flush;
  logic dir_rev, dir_bad, dir_apply;
  logic [1:0] dir_new;
  logic step_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= bus.cmd_in;
      for (int i = 1; i < NS; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced  = sync_q[NS-1];
  assign op      = synced[5:3];
  assign arg     = synced[2:0];
  assign new_cmd = (synced[6] != ack_q);

  // game_over takes the RUN->OVER transition first; a same-cycle command is
  // then judged against OVER.
  assign over_now  = (state_q == S_RUN) && bus.game_over;
  assign eff_state = over_now ? S_OVER : state_q;

  always_comb begin
    nxt_state   = eff_state;
    set_err     = 1'b0;
    clr_err     = 1'b0;
    rst_pulse   = 1'b0;
    tmr_clr     = 1'b0;
    speed_we    = 1'b0;
    dir_push    = 1'b0;
    force_right = 1'b0;
    if (new_cmd) begin
      case (op)
        OP_NOP: ;
        OP_START:
          if (eff_state == S_IDLE || eff_state == S_OVER) begin
            nxt_state   = S_RUN;
            rst_pulse   = 1'b1;
            tmr_clr     = 1'b1;
            force_right = 1'b1;
          end else set_err = 1'b1;
        OP_PAUSE:
          if (eff_state == S_RUN) nxt_state = S_PAUSE;
          else set_err = 1'b1;
        OP_RESUME:
          if (eff_state == S_PAUSE) nxt_state = S_RUN;
          else set_err = 1'b1;
        OP_DIR:   dir_push = 1'b1;
        OP_SPEED: speed_we = 1'b1;
        OP_RESET_GAME: begin
          nxt_state = S_IDLE;
          rst_pulse = 1'b1;
          tmr_clr   = 1'b1;
          clr_err   = 1'b1;
        end
        OP_RSVD:  set_err = 1'b1;
        default: ;
      endcase
    end
  end

  assign flush = rst_pulse || (nxt_state == S_OVER && state_q != S_OVER);

`ifdef SNAKE_CMD_DIR_QUEUE_EN
  logic [1:0][1:0] q_q;
  logic [1:0]      qn_q;
  logic [1:0]      last_dir;
  logic            q_full, do_push;

  assign q_full    = (qn_q == 2'd2);
  assign last_dir  = (qn_q == 2'd0) ? dir_q : (qn_q == 2'd2) ? q_q[1] : q_q[0];
  assign dir_rev   = is_reverse(arg[1:0], last_dir);
  assign dir_bad   = dir_push && (dir_rev || q_full);
  assign do_push   = dir_push && !dir_bad;
  assign dir_apply = step_tick && (qn_q != 2'd0);
  assign dir_new   = q_q[0];

  // Push-with-pop only happens at depth 1, so the new entry lands in slot 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q  <= '0;
      qn_q <= '0;
    end else if (flush) begin
      qn_q <= '0;
    end else if (do_push && dir_apply) begin
      q_q[0] <= arg[1:0];
    end else if (do_push) begin
      q_q[qn_q[0]] <= arg[1:0];
      qn_q         <= qn_q + 2'd1;
    end else if (dir_apply) begin
      q_q[0] <= q_q[1];
      qn_q   <= qn_q - 2'd1;
    end
  end
`else
  logic [1:0] pend_q;
  logic       pend_vld_q;

  assign dir_rev   = is_reverse(arg[1:0], dir_q);
  assign dir_bad   = dir_push && dir_rev;
  assign dir_apply = step_tick && pend_vld_q;
  assign dir_new   = pend_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= DIR_UP;
      pend_vld_q <= 1'b0;
    end else if (flush) begin
      pend_vld_q <= 1'b0;
    end else if (dir_push && !dir_rev) begin
      pend_q     <= arg[1:0];
      pend_vld_q <= 1'b1;
    end else if (dir_apply) begin
      pend_vld_q <= 1'b0;
    end
  end
`endif

  snake_step_timer #(.TICK_BASE(TICK_BASE)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        ((state_q == S_RUN) && !bus.game_over),
    .clr       (tmr_clr),
    .speed     (speed_q),
    .step_tick (step_tick)
  );

  always_comb begin
    status_d                  = '0;
    status_d[STB_ACK]         = ack_q;
    status_d[STB_STATE +: 2]  = state_q;
    status_d[STB_DIR +: 2]    = dir_q;
    status_d[STB_ERR]         = err_q;
    status_d[STB_BUSY]        = new_cmd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      dir_q      <= DIR_RIGHT;
      speed_q    <= SPEED_RESET;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      game_rst_q <= 1'b0;
      status_q   <= STATUS_RESET;
    end else begin
      state_q <= nxt_state;
      if (new_cmd)  ack_q   <= synced[6];
      if (speed_we) speed_q <= arg;
      if (force_right)    dir_q <= DIR_RIGHT;
      else if (dir_apply) dir_q <= dir_new;
      if (clr_err)                 err_q <= 1'b0;
      else if (set_err || dir_bad) err_q <= 1'b1;
      game_rst_q <= rst_pulse;
      status_q   <= status_d;
    end
  end

  assign bus.step_tick  = step_tick;
  assign bus.dir        = dir_q;
  assign bus.game_rst   = game_rst_q;
  assign bus.status_out = status_q;

endmodule
